text_mode_gen: RTL

TEXT_MODE_GEN -- requirements
Module: text_mode_gen

---
 rtl/text_mode_gen.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/text_mode_gen.sv
// Character-cell text-mode video generator: raster timing, screen/font fetch, colour, cursor and blink.
// Latency: 3 enabled pixels from counter state to every output; no backpressure, pix_ce_i=0 freezes all state.
module text_mode_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter bit SYNC_POL   = 1'b0,
    parameter int BLINK_LOG2 = 4,
    localparam int ADDR_W    = $clog2(COLS*ROWS),
    localparam int SY_W      = $clog2(CHAR_H)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_ce_i,
    output logic [ADDR_W-1:0]    screen_addr_o,
    input  logic [7:0]           chr_i,
    input  logic [7:0]           attr_i,
    output logic [8+SY_W-1:0]    font_addr_o,
    input  logic [CHAR_W-1:0]    font_i,
    input  logic [6:0]           cursor_col_i,
    input  logic [4:0]           cursor_row_i,
    input  logic                 cursor_en_i,
    output logic [3:0]           r_vga_o,
    output logic [3:0]           g_vga_o,
    output logic [3:0]           b_vga_o,
    output logic                 h_sync_o,
    output logic                 v_sync_o,
    output logic                 de_o,
    output logic                 frame_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int SX_W    = $clog2(CHAR_W);
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(ROWS + 1);
    localparam int BC_W    = BLINK_LOG2 + 1;

    if (H_ACTIVE != COLS*CHAR_W || V_ACTIVE != ROWS*CHAR_H) begin : g_geometry_check
        $error("text_mode_gen: active area must exactly cover the character grid");
    end

    typedef struct packed {
        logic            de;
        logic            hs;
        logic            vs;
        logic            fr;
        logic            hit;
        logic            blink;
        logic [SX_W-1:0] subx;
    } pix_meta_t;

    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [SX_W-1:0]   subx_q, subx_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [SY_W-1:0]   suby_q, suby_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] rbase_q, rbase_d;
    logic [BC_W-1:0]   blink_q, blink_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    pix_meta_t         s1_q, s1_d;
    logic [SY_W-1:0]   s1_suby_q, s1_suby_d;

    logic [8+SY_W-1:0] fa_q, fa_d;
    pix_meta_t         s2_q, s2_d;
    logic [7:0]        s2_attr_q, s2_attr_d;

    logic [3:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, frame_q, frame_d;

    logic              in_active;
    logic              cur_hit;
    logic              glyph_bit;
    logic              pix_on;
    logic [3:0]        irgb;

    function automatic logic [3:0] level(input logic chan, input logic inten);
        return (chan ? 4'hA : 4'h0) + (inten ? 4'h5 : 4'h0);
    endfunction

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        subx_d    = subx_q;
        col_d     = col_q;
        suby_d    = suby_q;
        row_d     = row_q;
        rbase_d   = rbase_q;
        blink_d   = blink_q;
        addr_d    = addr_q;
        s1_d      = s1_q;
        s1_suby_d = s1_suby_q;
        fa_d      = fa_q;
        s2_d      = s2_q;
        s2_attr_d = s2_attr_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        de_d      = de_q;
        frame_d   = 1'b0;

        in_active = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        // Range checks on the cursor stop wide cursor values aliasing onto a real cell.
        cur_hit   = cursor_en_i && !blink_q[BLINK_LOG2] && in_active
                    && (int'(cursor_col_i) < COLS) && (int'(cursor_row_i) < ROWS)
                    && (int'(col_q) == int'(cursor_col_i))
                    && (int'(row_q) == int'(cursor_row_i))
                    && (int'(suby_q) >= CHAR_H - 2);
        glyph_bit = font_i[SX_W'(CHAR_W - 1) - s2_q.subx] && !(s2_attr_q[7] && s2_q.blink);
        pix_on    = glyph_bit ^ s2_q.hit;
        irgb      = pix_on ? s2_attr_q[3:0] : {1'b0, s2_attr_q[6:4]};

        if (pix_ce_i) begin
            if (int'(h_q) == H_TOTAL - 1) begin
                h_d    = '0;
                subx_d = '0;
                col_d  = '0;
                if (int'(v_q) == V_TOTAL - 1) begin
                    v_d     = '0;
                    suby_d  = '0;
                    row_d   = '0;
                    rbase_d = '0;
                    blink_d = blink_q + 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                    if (int'(suby_q) == CHAR_H - 1) begin
                        suby_d  = '0;
                        row_d   = row_q + 1'b1;
                        rbase_d = rbase_q + ADDR_W'(COLS);
                    end else begin
                        suby_d = suby_q + 1'b1;
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
                if (int'(subx_q) == CHAR_W - 1) begin
                    subx_d = '0;
                    col_d  = col_q + 1'b1;
                end else begin
                    subx_d = subx_q + 1'b1;
                end
            end

            if (in_active) begin
                addr_d = rbase_q + ADDR_W'(col_q);
            end
            s1_d.de    = in_active;
            s1_d.hs    = (int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
            s1_d.vs    = (int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);
            s1_d.fr    = (h_q == '0) && (v_q == '0);
            s1_d.hit   = cur_hit;
            s1_d.blink = blink_q[BLINK_LOG2];
            s1_d.subx  = subx_q;
            s1_suby_d  = suby_q;

            fa_d      = {chr_i, s1_suby_q};
            s2_d      = s1_q;
            s2_attr_d = attr_i;

            r_d     = s2_q.de ? level(irgb[2], irgb[3]) : 4'h0;
            g_d     = s2_q.de ? level(irgb[1], irgb[3]) : 4'h0;
            b_d     = s2_q.de ? level(irgb[0], irgb[3]) : 4'h0;
            hs_d    = s2_q.hs ? SYNC_POL : ~SYNC_POL;
            vs_d    = s2_q.vs ? SYNC_POL : ~SYNC_POL;
            de_d    = s2_q.de;
            frame_d = s2_q.fr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            subx_q    <= '0;
            col_q     <= '0;
            suby_q    <= '0;
            row_q     <= '0;
            rbase_q   <= '0;
            blink_q   <= '0;
            addr_q    <= '0;
            s1_q      <= '0;
            s1_suby_q <= '0;
            fa_q      <= '0;
            s2_q      <= '0;
            s2_attr_q <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            de_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            subx_q    <= subx_d;
            col_q     <= col_d;
            suby_q    <= suby_d;
            row_q     <= row_d;
            rbase_q   <= rbase_d;
            blink_q   <= blink_d;
            addr_q    <= addr_d;
            s1_q      <= s1_d;
            s1_suby_q <= s1_suby_d;
            fa_q      <= fa_d;
            s2_q      <= s2_d;
            s2_attr_q <= s2_attr_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            frame_q   <= frame_d;
        end
    end

    assign screen_addr_o = addr_q;
    assign font_addr_o   = fa_q;
    assign r_vga_o       = r_q;
    assign g_vga_o       = g_q;
    assign b_vga_o       = b_q;
    assign h_sync_o      = hs_q;
    assign v_sync_o      = vs_q;
    assign de_o          = de_q;
    assign frame_o       = frame_q;

endmodule
